seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/alu_pkg.sv | 46 ++++
 rtl/alu_muldiv_iter.sv | 109 ++++++++++
 rtl/seq_alu.sv | 226 ++++++++++++++++++++++
 tb/tb_seq_alu.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg -- shared definitions for the ALU family (existing ALU, decode,
// seq_alu): opcode encodings, flag bit positions and the sequencer state type.
//
// Single-cycle opcode behaviour (r = result; flags not named pass through):
//   NOP  r=0                  NOT  r=~a, Z N          MOV  r=b
//   STD  r=a (store address)  LDD  r=b (load address)
//   INC  r=a+1, Z N C         DEC  r=a-1, Z N C(borrow)
//   ADD  r=a+b, V Z N C       SUB  r=a-b, V Z N C(borrow)
//   AND  r=a&b, Z N           OR   r=a|b, Z N
//   SHL  r=a<<b, Z N C        SHR  r=a>>b, Z N C
//   SETC r=0, C=1             CLRC r=0, C=0
//   JZ   r=a (target), Z=0    JN   r=a, N=0    JC  r=a, C=0    JMP r=a
// Iterative: MUL (unsigned product), DIV (unsigned quotient/remainder).
// Encodings >= OP_COUNT are undefined and decode to NOP.
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int FLAG_C = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 3;

    typedef enum logic [4:0] {
        OP_NOP  = 5'd0,  OP_NOT  = 5'd1,  OP_MOV  = 5'd2,  OP_STD  = 5'd3,
        OP_LDD  = 5'd4,  OP_INC  = 5'd5,  OP_DEC  = 5'd6,  OP_ADD  = 5'd7,
        OP_SUB  = 5'd8,  OP_AND  = 5'd9,  OP_OR   = 5'd10, OP_SHL  = 5'd11,
        OP_SHR  = 5'd12, OP_SETC = 5'd13, OP_CLRC = 5'd14, OP_JZ   = 5'd15,
        OP_JN   = 5'd16, OP_JC   = 5'd17, OP_JMP  = 5'd18, OP_MUL  = 5'd19,
        OP_DIV  = 5'd20
    } alu_op_e;

    localparam int unsigned OP_COUNT = 21;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    // Maps a raw opcode field onto the enum; anything undefined becomes NOP.
    function automatic alu_op_e op_decode(input logic [31:0] raw);
        return (raw < OP_COUNT) ? alu_op_e'(raw[4:0]) : OP_NOP;
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// ---------------------------------------------------------------------------
// alu_muldiv_iter -- one-bit-per-cycle unsigned shift-add multiplier and
// restoring divider sharing one pair of WIDTH-bit registers.
//
// Ports:
//   clk, rst_n    clock, synchronous active-low reset (aborts any operation)
//   start_i       load a_i/b_i and begin; only pulsed while idle
//   is_div_i      1 = divide a_i / b_i, 0 = multiply a_i * b_i
//   a_i, b_i      operands (b_i is the divisor for DIV, nonzero)
//   done_o        high during the last of the WIDTH iteration cycles; the
//                 final lo_o/hi_o are valid from the next cycle and held
//                 until the next start_i
//   lo_o, hi_o    MUL: {hi_o, lo_o} = product; DIV: lo_o = quotient,
//                 hi_o = remainder
// ---------------------------------------------------------------------------
module alu_muldiv_iter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] hi_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic             run_q, run_d;
    logic             is_div_q, is_div_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;       // MUL partial product high / DIV remainder
    logic [WIDTH-1:0] lo_q, lo_d;       // MUL multiplier->product low / DIV dividend->quotient
    logic [WIDTH-1:0] opnd_q, opnd_d;   // multiplicand or divisor

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;

    // NOTE: next-state logic assigns every _d a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        run_d    = run_q;
        is_div_d = is_div_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;

        add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        rem_sh  = {hi_q, lo_q[WIDTH-1]};
        // The remainder is always below the divisor, so WIDTH+1 bits hold the
        // trial difference and its top bit is the borrow.
        trial   = rem_sh - {1'b0, opnd_q};

        if (start_i) begin
            run_d    = 1'b1;
            is_div_d = is_div_i;
            cnt_d    = '0;
            hi_d     = '0;
            lo_d     = a_i;
            opnd_d   = b_i;
        end else if (run_q) begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
                run_d = 1'b0;
            end
            if (is_div_q) begin
                if (!trial[WIDTH]) begin
                    hi_d = trial[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    hi_d = rem_sh[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                hi_d = add_sum[WIDTH:1];
                lo_d = {add_sum[0], lo_q[WIDTH-1:1]};
            end
        end
    end

    // NOTE: state registers update with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_q    <= 1'b0;
            is_div_q <= 1'b0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
        end else begin
            run_q    <= run_d;
            is_div_q <= is_div_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opnd_q   <= opnd_d;
        end
    end

    assign done_o = run_q && (cnt_q == LAST);
    assign lo_o   = lo_q;
    assign hi_o   = hi_q;

endmodule

// File: rtl/seq_alu.sv
// ---------------------------------------------------------------------------
// seq_alu -- sequential ALU with valid/ready request and result handshakes.
// Single-cycle ops complete one cycle after acceptance; MUL and DIV (nonzero
// divisor) run on alu_muldiv_iter and complete WIDTH+1 cycles after it.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid / in_ready   request handshake (in_ready only in IDLE)
//   op, a, b, flags_in    opcode, Rdst, Rsrc/shift amount, flags {V,Z,N,C}
//   out_valid / out_ready result handshake (out_valid only in DONE)
//   result, result_hi     result; MUL high half / DIV remainder, else 0
//   flags_out             resulting flags {V,Z,N,C}
//   busy                  high whenever not IDLE
// WIDTH must be at least 4.
// ---------------------------------------------------------------------------
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int OP_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       flags_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic [3:0]       flags_out,
    output logic             busy
);

    localparam int MSB = WIDTH - 1;
    localparam logic [WIDTH-1:0] SHAMT_MAX = WIDTH'(WIDTH);

    alu_state_e       state_q, state_d;
    alu_op_e          op_in, op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [3:0]       flags_q;

    logic             accept;
    logic             iter_op;
    logic             iter_done;
    logic [WIDTH-1:0] iter_lo, iter_hi;

    logic [WIDTH-1:0] res_d, res_hi_d;
    logic [3:0]       flg_d;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shl_w, shr_w;

    assign op_in   = op_decode(32'(op));
    assign iter_op = (op_in == OP_MUL) || ((op_in == OP_DIV) && (b != '0));
    assign accept  = in_valid && (state_q == ST_IDLE);

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (accept && iter_op),
        .is_div_i (op_in == OP_DIV),
        .a_i      (a),
        .b_i      (b),
        .done_o   (iter_done),
        .lo_o     (iter_lo),
        .hi_o     (iter_hi)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_NOP;
            a_q     <= '0;
            b_q     <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q    <= op_in;
                a_q     <= a;
                b_q     <= b;
                flags_q <= flags_in;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = iter_op ? ST_BUSY : ST_DONE;
                end
            end
            ST_BUSY: begin
                if (iter_done) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Result is a pure function of the captured request (and the held
    // iterative result), so it stays stable for the whole DONE state.
    always_comb begin
        res_d    = '0;
        res_hi_d = '0;
        flg_d    = flags_q;
        sum      = '0;
        // Bit WIDTH of shl_w / bit 0 of shr_w is the last bit shifted out
        // for amounts 1..WIDTH, and 0 for amount 0.
        shl_w    = {1'b0, a_q} << b_q;
        shr_w    = {a_q, 1'b0} >> b_q;

        case (op_q)
            OP_NOT: res_d = ~a_q;
            OP_MOV: res_d = b_q;
            OP_STD: res_d = a_q;
            OP_LDD: res_d = b_q;
            OP_INC: begin
                sum           = {1'b0, a_q} + (WIDTH+1)'(1);
                res_d         = sum[WIDTH-1:0];
                flg_d[FLAG_C] = sum[WIDTH];
            end
            OP_DEC: begin
                sum           = {1'b0, a_q} - (WIDTH+1)'(1);
                res_d         = sum[WIDTH-1:0];
                flg_d[FLAG_C] = sum[WIDTH];
            end
            OP_ADD: begin
                sum           = {1'b0, a_q} + {1'b0, b_q};
                res_d         = sum[WIDTH-1:0];
                flg_d[FLAG_C] = sum[WIDTH];
                flg_d[FLAG_V] = (a_q[MSB] == b_q[MSB]) && (sum[MSB] != a_q[MSB]);
            end
            OP_SUB: begin
                sum           = {1'b0, a_q} - {1'b0, b_q};
                res_d         = sum[WIDTH-1:0];
                flg_d[FLAG_C] = sum[WIDTH];
                flg_d[FLAG_V] = (a_q[MSB] != b_q[MSB]) && (sum[MSB] != a_q[MSB]);
            end
            OP_AND: res_d = a_q & b_q;
            OP_OR:  res_d = a_q | b_q;
            OP_SHL: begin
                if (b_q <= SHAMT_MAX) begin
                    res_d         = shl_w[WIDTH-1:0];
                    flg_d[FLAG_C] = shl_w[WIDTH];
                end else begin
                    flg_d[FLAG_C] = 1'b0;
                end
            end
            OP_SHR: begin
                if (b_q <= SHAMT_MAX) begin
                    res_d         = shr_w[WIDTH:1];
                    flg_d[FLAG_C] = shr_w[0];
                end else begin
                    flg_d[FLAG_C] = 1'b0;
                end
            end
            OP_SETC: flg_d[FLAG_C] = 1'b1;
            OP_CLRC: flg_d[FLAG_C] = 1'b0;
            OP_JZ: begin
                res_d         = a_q;
                flg_d[FLAG_Z] = 1'b0;
            end
            OP_JN: begin
                res_d         = a_q;
                flg_d[FLAG_N] = 1'b0;
            end
            OP_JC: begin
                res_d         = a_q;
                flg_d[FLAG_C] = 1'b0;
            end
            OP_JMP: res_d = a_q;
            OP_MUL: begin
                res_d         = iter_lo;
                res_hi_d      = iter_hi;
                flg_d[FLAG_Z] = ({iter_hi, iter_lo} == '0);
                flg_d[FLAG_N] = iter_hi[MSB];
                flg_d[FLAG_C] = |iter_hi;
                flg_d[FLAG_V] = |iter_hi;
            end
            OP_DIV: begin
                if (b_q == '0) begin
                    res_d         = '1;
                    res_hi_d      = a_q;
                    flg_d[FLAG_V] = 1'b1;
                end else begin
                    res_d         = iter_lo;
                    res_hi_d      = iter_hi;
                    flg_d[FLAG_Z] = (iter_lo == '0);
                    flg_d[FLAG_N] = iter_lo[MSB];
                    flg_d[FLAG_V] = 1'b0;
                end
            end
            default: ;
        endcase

        if (op_q inside {OP_NOT, OP_INC, OP_DEC, OP_ADD, OP_SUB,
                         OP_AND, OP_OR, OP_SHL, OP_SHR}) begin
            flg_d[FLAG_Z] = (res_d == '0);
            flg_d[FLAG_N] = res_d[MSB];
        end
    end

    // Outputs are forced to zero outside DONE, so a result cut short by
    // reset can never appear.
    assign result    = (state_q == ST_DONE) ? res_d    : '0;
    assign result_hi = (state_q == ST_DONE) ? res_hi_d : '0;
    assign flags_out = (state_q == ST_DONE) ? flg_d    : '0;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_seq_alu.sv
// ---------------------------------------------------------------------------
// tb_seq_alu -- self-checking bench for seq_alu (WIDTH=16, OP_W=5).
// Directed cases for the documented corner points, a reset-during-MUL case,
// then randomized requests compared against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_seq_alu;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  flags_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic [15:0] result_hi;
    logic [3:0]  flags_out;
    logic        busy;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total    = 0;

    seq_alu #(.WIDTH(16), .OP_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .flags_in  (flags_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .flags_out (flags_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [15:0] res;
        logic [15:0] hi;
        logic [3:0]  fl;
        int          lat;
    } exp_t;

    // Reference model: plain integer arithmetic on the documented op rules.
    function automatic exp_t model(input logic [4:0] opc, input logic [15:0] av,
                                   input logic [15:0] bv, input logic [3:0] fi);
        exp_t   e;
        longint full;
        longint p;
        int     ss;
        logic   v, z, n, c, upd_zn;
        {v, z, n, c} = fi;
        upd_zn = 1'b0;
        e.res  = '0;
        e.hi   = '0;
        e.lat  = 1;
        case (opc)
            OP_NOT: begin e.res = ~av; upd_zn = 1'b1; end
            OP_MOV: e.res = bv;
            OP_STD: e.res = av;
            OP_LDD: e.res = bv;
            OP_INC: begin
                full = longint'(av) + 1; e.res = full[15:0];
                c = (full > 65535); upd_zn = 1'b1;
            end
            OP_DEC: begin
                full = longint'(av) - 1; e.res = full[15:0];
                c = (full < 0); upd_zn = 1'b1;
            end
            OP_ADD: begin
                full = longint'(av) + longint'(bv); e.res = full[15:0];
                c = (full > 65535);
                ss = int'($signed(av)) + int'($signed(bv));
                v = (ss > 32767) || (ss < -32768); upd_zn = 1'b1;
            end
            OP_SUB: begin
                full = longint'(av) - longint'(bv); e.res = full[15:0];
                c = (full < 0);
                ss = int'($signed(av)) - int'($signed(bv));
                v = (ss > 32767) || (ss < -32768); upd_zn = 1'b1;
            end
            OP_AND: begin e.res = av & bv; upd_zn = 1'b1; end
            OP_OR:  begin e.res = av | bv; upd_zn = 1'b1; end
            OP_SHL: begin
                if (bv == 0) begin e.res = av; c = 1'b0; end
                else if (bv <= 16) begin
                    e.res = av << bv;
                    c = ((longint'(av) >> (16 - int'(bv))) & 1) != 0;
                end else begin e.res = '0; c = 1'b0; end
                upd_zn = 1'b1;
            end
            OP_SHR: begin
                if (bv == 0) begin e.res = av; c = 1'b0; end
                else if (bv <= 16) begin
                    e.res = av >> bv;
                    c = ((longint'(av) >> (int'(bv) - 1)) & 1) != 0;
                end else begin e.res = '0; c = 1'b0; end
                upd_zn = 1'b1;
            end
            OP_SETC: c = 1'b1;
            OP_CLRC: c = 1'b0;
            OP_JZ:   begin e.res = av; z = 1'b0; end
            OP_JN:   begin e.res = av; n = 1'b0; end
            OP_JC:   begin e.res = av; c = 1'b0; end
            OP_JMP:  e.res = av;
            OP_MUL: begin
                p = longint'(av) * longint'(bv);
                e.res = p[15:0]; e.hi = p[31:16];
                z = (p == 0); n = p[31];
                c = (p >> 16) != 0; v = c; e.lat = 17;
            end
            OP_DIV: begin
                if (bv == 0) begin
                    e.res = 16'hFFFF; e.hi = av; v = 1'b1;
                end else begin
                    e.res = av / bv; e.hi = av % bv;
                    z = (e.res == 0); n = e.res[15]; v = 1'b0; e.lat = 17;
                end
            end
            default: ;
        endcase
        if (upd_zn) begin
            z = (e.res == 0);
            n = e.res[15];
        end
        e.fl = {v, z, n, c};
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One full request: accept, scramble inputs, wait for DONE (bounded),
    // check outputs, optionally stall out_ready, then handshake.
    task automatic run_op(input string name, input logic [4:0] op_v, input logic [15:0] a_v,
                          input logic [15:0] b_v, input logic [3:0] f_v, input int stall);
        exp_t e;
        int   lat;
        logic hold_ok;
        e = model(op_v, a_v, b_v, f_v);
        @(negedge clk);
        check($sformatf("%s.in_ready_idle", name), 32'(in_ready), 32'd1);
        in_valid = 1'b1; op = op_v; a = a_v; b = b_v; flags_in = f_v; out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op = 5'($urandom); a = 16'($urandom); b = 16'($urandom); flags_in = 4'($urandom);
        lat = 0;
        hold_ok = 1'b1;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (out_valid === 1'b1) break;
            if (in_ready !== 1'b0 || busy !== 1'b1) hold_ok = 1'b0;
        end
        check($sformatf("%s.latency", name), 32'(lat), 32'(e.lat));
        check($sformatf("%s.busy_wait", name), 32'(hold_ok), 32'd1);
        check($sformatf("%s.out_valid", name), 32'(out_valid), 32'd1);
        check($sformatf("%s.result", name), 32'(result), 32'(e.res));
        check($sformatf("%s.result_hi", name), 32'(result_hi), 32'(e.hi));
        check($sformatf("%s.flags", name), 32'(flags_out), 32'(e.fl));
        check($sformatf("%s.in_ready_done", name), 32'(in_ready), 32'd0);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check($sformatf("%s.stall%0d.result", name, i), 32'(result), 32'(e.res));
            check($sformatf("%s.stall%0d.result_hi", name, i), 32'(result_hi), 32'(e.hi));
            check($sformatf("%s.stall%0d.flags", name, i), 32'(flags_out), 32'(e.fl));
            check($sformatf("%s.stall%0d.valid_ready", name, i),
                  32'({out_valid, in_ready}), 32'b10);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic       seen_valid;
        logic [4:0] r_op;
        logic [15:0] r_a, r_b;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; a = '0; b = '0; flags_in = '0;
        repeat (3) @(negedge clk);
        check("rst.in_ready",  32'(in_ready),  32'd1);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.busy",      32'(busy),      32'd0);
        check("rst.result",    32'(result),    32'd0);
        check("rst.result_hi", 32'(result_hi), 32'd0);
        check("rst.flags",     32'(flags_out), 32'd0);
        rst_n = 1'b1;

        run_op("add_ovf", OP_ADD, 16'h7FFF, 16'h0001, 4'b0000, 0);
        run_op("mul",     OP_MUL, 16'h1234, 16'h0010, 4'b0000, 2);
        run_op("div",     OP_DIV, 16'd100,  16'd7,    4'b0001, 0);
        run_op("div0",    OP_DIV, 16'd5,    16'd0,    4'b0111, 0);
        run_op("shl1",    OP_SHL, 16'h8001, 16'd1,    4'b0000, 0);
        run_op("shr16",   OP_SHR, 16'h8001, 16'd16,   4'b0000, 0);
        run_op("shr17",   OP_SHR, 16'h8001, 16'd17,   4'b0001, 0);
        run_op("shl0",    OP_SHL, 16'h1234, 16'd0,    4'b0001, 0);
        run_op("sub_bp",  OP_SUB, 16'h0003, 16'h0005, 4'b0000, 3);
        run_op("dec0",    OP_DEC, 16'h0000, 16'h0000, 4'b1000, 0);
        run_op("inc_max", OP_INC, 16'hFFFF, 16'h0000, 4'b0000, 0);
        run_op("undef",   5'd25,  16'h1111, 16'h2222, 4'b1010, 0);

        // Reset in BUSY cycle 5 of a MUL.
        @(negedge clk);
        in_valid = 1'b1; op = OP_MUL; a = 16'hFFFF; b = 16'hFFFF; flags_in = 4'b0000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("rstmid.busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rstmid.in_ready",  32'(in_ready),  32'd1);
        check("rstmid.out_valid", 32'(out_valid), 32'd0);
        check("rstmid.busy",      32'(busy),      32'd0);
        check("rstmid.result",    32'(result),    32'd0);
        check("rstmid.result_hi", 32'(result_hi), 32'd0);
        check("rstmid.flags",     32'(flags_out), 32'd0);
        seen_valid = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen_valid = 1'b1;
        end
        check("rstmid.no_stale_result", 32'(seen_valid), 32'd0);
        run_op("post_rst_add", OP_ADD, 16'd2, 16'd3, 4'b0000, 0);

        // Randomized requests against the reference model.
        for (int i = 0; i < 120; i++) begin
            r_op = 5'($urandom_range(0, 31));
            case ($urandom_range(0, 4))
                0: r_a = 16'h0000;
                1: r_a = 16'hFFFF;
                2: r_a = 16'h8000;
                default: r_a = 16'($urandom);
            endcase
            r_b = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 18)) : 16'($urandom);
            run_op($sformatf("rnd%0d", i), r_op, r_a, r_b, 4'($urandom), $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
